gpr_sb_file: RTL and testbench
==============================

// Module: gpr_sb_file
// PURPOSE
//   Parametrised general-purpose register file for the pipelined CPU core.
//   Provides 2 combinational read ports, 1 write port, optional write-to-read bypass,
//   and a per-register pending-write scoreboard that tells decode when an operand is not ready.
//   Sits between decode (read, issue) and writeback (write, retire).
// PARAMETERS
//   DATA_W   32  register width in bits
//   ADDR_W   5   register index width; depth = 2**ADDR_W
//   PEND_W   2   per-register pending-write counter width; max outstanding writes = 2**PEND_W-1
//   BYPASS   1   1: a same-cycle write is visible on the read ports; 0: visible next cycle
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-high reset
//   rd_addr1   in   ADDR_W   read port 1 index
//   rd_addr2   in   ADDR_W   read port 2 index
//   rd_data1   out  DATA_W   read port 1 data (combinational)
//   rd_data2   out  DATA_W   read port 2 data (combinational)
//   rd_busy1   out  1        rd_addr1 has an outstanding write
//   rd_busy2   out  1        rd_addr2 has an outstanding write
//   we         in   1        writeback strobe
//   wr_addr    in   ADDR_W   writeback index
//   wr_data    in   DATA_W   writeback data
//   iss_valid  in   1        decode issues an instruction that will write iss_dst
//   iss_dst    in   ADDR_W   destination index of the issued instruction
//   iss_ready  out  1        iss_dst counter not saturated; issue accepted only if high
//   wb_err     out  1        sticky: writeback retired a register with a zero counter
// BEHAVIOUR
//   Reset (async, any time, including mid-operation):
//     all registers = 0, all counters = 0, wb_err = 0
//     => rd_data* = 0, rd_busy* = 0, iss_ready = 1
//   Register 0: reads always 0. Writes to it are dropped. Issue to it never changes a counter.
//     Writeback to it never touches a counter and never flags wb_err.
//   Write: on posedge clk with we=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
//   Read (0-cycle):
//     - rd_dataN = 0 when rd_addrN==0.
//     - BYPASS=1 and we=1 and wr_addr==rd_addrN: rd_dataN = wr_data.
//     - Otherwise rd_dataN = reg[rd_addrN].
//   Scoreboard counter cnt[r], r != 0. On posedge clk:
//     inc = iss_valid & iss_ready & iss_dst==r
//     dec = we & wr_addr==r & cnt[r]!=0
//     inc & dec -> unchanged; inc only -> +1; dec only -> -1.
//   Saturation: iss_ready = (iss_dst==0) | (cnt[iss_dst] != 2**PEND_W-1).
//     Counts the same-cycle dec: a retire to iss_dst this cycle makes iss_ready = 1.
//     Issue while iss_ready=0 is ignored; the counter never wraps.
//   Underflow: we=1, wr_addr!=0, cnt[wr_addr]==0 -> write still performed, counter stays 0,
//     wb_err <= 1. wb_err clears only on rst.
//   rd_busyN = (rd_addrN != 0) & (cnt[rd_addrN] - byp != 0),
//     where byp = BYPASS & we & wr_addr==rd_addrN & cnt!=0.
//     A retire of the last pending write is therefore seen as ready in the same cycle when BYPASS=1.
//   A same-cycle issue does not affect rd_busy* until the next cycle.
// STRUCTURE
//   Shared package cpu_pkg: GPR_DATA_W=32, GPR_ADDR_W=5, REG_ZERO=0, typedefs gpr_idx_t, gpr_word_t.
//   Sub-module gpr_pend_ctr: one PEND_W-bit up/down counter with inc, dec, sat and zero outputs.
//     Instantiated via generate for r = 1..2**ADDR_W-1.
//   Storage: plain register array with async reset; no RAM macro (needs async reset clear).
// TESTING
//   1. rst pulse mid-run after writing r5=0xDEADBEEF -> rd_data(r5)=0, all busy=0, iss_ready=1,
//      wb_err=0, with no clock edge needed.
//   2. we=1, wr_addr=0, wr_data=0x12345678; read r0 -> 0 on both ports, wb_err stays 0.
//   3. BYPASS=1: we=1, r7<=0xA5A5A5A5, rd_addr1=7 same cycle -> rd_data1=0xA5A5A5A5.
//      BYPASS=0 -> old value this cycle, new value next cycle.
//   4. Issue r3 three times (PEND_W=2) -> cnt=3, iss_ready=0 for iss_dst=3.
//      4th issue ignored. Retire r3 with issue same cycle -> cnt stays 3.
//   5. Issue r9 once, then retire r9 with rd_addr2=9 -> rd_busy2=0 that cycle (BYPASS=1).
//      rd_busy2=1 that cycle (BYPASS=0).
//   6. Retire r4 with cnt=0 -> r4 written, wb_err=1 next cycle, held until rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths, the hard-wired zero register index and word/index types.
//   GPR_DATA_W  default register width
//   GPR_ADDR_W  default register index width
//   REG_ZERO    index of the register that always reads 0
package cpu_pkg;
    localparam int GPR_DATA_W = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int REG_ZERO   = 0;
    typedef logic [GPR_ADDR_W-1:0] gpr_idx_t;
    typedef logic [GPR_DATA_W-1:0] gpr_word_t;
endpackage

// File: rtl/gpr_pend_ctr.sv
// gpr_pend_ctr: pending-write counter for one register, counting issued but not yet retired writes.
//   clk, rst  clock, asynchronous active-high reset
//   inc       an accepted issue targets this register
//   dec       a retire targets this register (caller only asserts it when the count is non-zero)
//   cnt       current number of outstanding writes
//   sat       count is at its maximum
//   zero      count is zero
module gpr_pend_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat,
    output logic         zero
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (inc && !dec) cnt <= cnt + 1'b1;
        else if (dec && !inc) cnt <= cnt - 1'b1;
    end
    assign sat  = &cnt;
    assign zero = cnt == '0;
endmodule

// File: rtl/gpr_sb_file.sv
// gpr_sb_file: register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending-write scoreboard.
//   clk, rst              clock, asynchronous active-high reset
//   rd_addr1/2            read indices
//   rd_data1/2            read data (combinational)
//   rd_busy1/2            read index still has an outstanding write
//   we, wr_addr, wr_data  writeback / retire port
//   iss_valid, iss_dst    decode issues an instruction writing iss_dst
//   iss_ready             issue to iss_dst will be accepted
//   wb_err                sticky: a retire hit a register with no outstanding write
module gpr_sb_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W,
    parameter int PEND_W = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              iss_ready,
    output logic              wb_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
    logic [DATA_W-1:0] regs [DEPTH];
    logic [PEND_W-1:0] cnt [DEPTH];
    logic [DEPTH-1:0]  sat;
    logic [DEPTH-1:0]  zero;
    logic              wr_ok;
    logic              byp1;
    logic              byp2;
    assign wr_ok = we && wr_addr != ZERO;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wb_err <= 1'b0;
        else if (wr_ok && zero[wr_addr]) wb_err <= 1'b1;
    end
    assign rd_data1 = rd_addr1 == ZERO ? '0 :
                      (BYPASS != 0 && we && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
    assign rd_data2 = rd_addr2 == ZERO ? '0 :
                      (BYPASS != 0 && we && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
    // A retire of a pending write counts as already done for the reader when bypassing.
    assign byp1 = BYPASS != 0 && we && wr_addr == rd_addr1 && !zero[rd_addr1];
    assign byp2 = BYPASS != 0 && we && wr_addr == rd_addr2 && !zero[rd_addr2];
    assign rd_busy1 = rd_addr1 != ZERO && (cnt[rd_addr1] - PEND_W'(byp1)) != '0;
    assign rd_busy2 = rd_addr2 != ZERO && (cnt[rd_addr2] - PEND_W'(byp2)) != '0;
    // A saturated counter is non-zero, so any same-cycle retire to it frees a slot.
    assign iss_ready = iss_dst == ZERO || !sat[iss_dst] || (we && wr_addr == iss_dst);
    assign cnt[0]  = '0;
    assign sat[0]  = 1'b0;
    assign zero[0] = 1'b1;
    for (genvar r = 1; r < DEPTH; r++) begin : g_ctr
        gpr_pend_ctr #(.W(PEND_W)) u_ctr (
            .clk  (clk),
            .rst  (rst),
            .inc  (iss_valid && iss_ready && iss_dst == ADDR_W'(r)),
            .dec  (we && wr_addr == ADDR_W'(r) && !zero[r]),
            .cnt  (cnt[r]),
            .sat  (sat[r]),
            .zero (zero[r])
        );
    end
endmodule

// File: tb/tb_gpr_sb_file.sv
// tb_gpr_sb_file: directed checks of a bypassing and a non-bypassing register file driven in parallel.
module tb_gpr_sb_file;
    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_dst;
    logic [31:0] b1_rd1, b1_rd2, b0_rd1, b0_rd2;
    logic        b1_bz1, b1_bz2, b1_rdy, b1_err;
    logic        b0_bz1, b0_bz2, b0_rdy, b0_err;
    int tests = 0;
    int fails = 0;

    gpr_sb_file #(.DATA_W(32), .ADDR_W(5), .PEND_W(2), .BYPASS(1)) u_b1 (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b1_rd1), .rd_data2(b1_rd2), .rd_busy1(b1_bz1), .rd_busy2(b1_bz2),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
        .iss_dst(iss_dst), .iss_ready(b1_rdy), .wb_err(b1_err)
    );
    gpr_sb_file #(.DATA_W(32), .ADDR_W(5), .PEND_W(2), .BYPASS(0)) u_b0 (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b0_rd1), .rd_data2(b0_rd2), .rd_busy1(b0_bz1), .rd_busy2(b0_bz2),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid),
        .iss_dst(iss_dst), .iss_ready(b0_rdy), .wb_err(b0_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic iv, input logic [4:0] id);
        @(negedge clk);
        we = w; wr_addr = wa; wr_data = wd; iss_valid = iv; iss_dst = id;
        #1;
    endtask

    task automatic test_reset;
        rst = 1; we = 0; wr_addr = 0; wr_data = 0; iss_valid = 0; iss_dst = 5;
        rd_addr1 = 5; rd_addr2 = 5;
        #1;
        tests++; if (b1_rd1 !== 32'h0 || b0_rd2 !== 32'h0) begin fails++; $display("FAIL reset_data got %h/%h exp 0", b1_rd1, b0_rd2); end
        tests++; if ({b1_bz1, b1_bz2, b0_bz1, b0_bz2, b1_err, b0_err} !== 6'b0) begin fails++; $display("FAIL reset_flags got %b%b%b%b%b%b exp 000000", b1_bz1, b1_bz2, b0_bz1, b0_bz2, b1_err, b0_err); end
        tests++; if (b1_rdy !== 1'b1 || b0_rdy !== 1'b1) begin fails++; $display("FAIL reset_ready got %b/%b exp 1", b1_rdy, b0_rdy); end
        @(negedge clk); rst = 0;
        // write r5 while issuing r5: counter 0 at retire -> underflow, then counter 1 from the issue
        step(1, 5, 32'hDEADBEEF, 1, 5);
        step(0, 0, 0, 0, 5);
        tests++; if (b1_rd1 !== 32'hDEADBEEF || b0_rd1 !== 32'hDEADBEEF) begin fails++; $display("FAIL pre_rst_data got %h/%h exp deadbeef", b1_rd1, b0_rd1); end
        tests++; if (b1_bz1 !== 1'b1 || b1_err !== 1'b1) begin fails++; $display("FAIL pre_rst_flags busy %b err %b exp 1 1", b1_bz1, b1_err); end
        #2 rst = 1;
        #1;
        tests++; if (b1_rd1 !== 32'h0 || b0_rd2 !== 32'h0) begin fails++; $display("FAIL async_rst_data got %h/%h exp 0", b1_rd1, b0_rd2); end
        tests++; if ({b1_bz1, b1_bz2, b0_bz1, b1_err, b0_err} !== 5'b0 || b1_rdy !== 1'b1) begin fails++; $display("FAIL async_rst_flags bz %b err %b rdy %b exp 0 0 1", b1_bz1, b1_err, b1_rdy); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_r0_write;
        rd_addr1 = 0; rd_addr2 = 0;
        step(1, 0, 32'h12345678, 0, 0);
        tests++; if (b1_rd1 !== 32'h0 || b1_rd2 !== 32'h0 || b0_rd1 !== 32'h0) begin fails++; $display("FAIL r0_bypass got %h/%h/%h exp 0", b1_rd1, b1_rd2, b0_rd1); end
        tests++; if (b1_bz1 !== 1'b0) begin fails++; $display("FAIL r0_busy got %b exp 0", b1_bz1); end
        step(0, 0, 0, 0, 0);
        tests++; if (b1_rd1 !== 32'h0 || b0_rd2 !== 32'h0) begin fails++; $display("FAIL r0_read got %h/%h exp 0", b1_rd1, b0_rd2); end
        tests++; if (b1_err !== 1'b0 || b0_err !== 1'b0) begin fails++; $display("FAIL r0_wb_err got %b/%b exp 0", b1_err, b0_err); end
    endtask

    task automatic test_bypass;
        rd_addr1 = 7; rd_addr2 = 0;
        step(0, 0, 0, 1, 7);
        step(1, 7, 32'hA5A5A5A5, 0, 0);
        tests++; if (b1_rd1 !== 32'hA5A5A5A5) begin fails++; $display("FAIL bypass1_data got %h exp a5a5a5a5", b1_rd1); end
        tests++; if (b0_rd1 !== 32'h0) begin fails++; $display("FAIL bypass0_old got %h exp 0", b0_rd1); end
        step(0, 0, 0, 0, 0);
        tests++; if (b1_rd1 !== 32'hA5A5A5A5 || b0_rd1 !== 32'hA5A5A5A5) begin fails++; $display("FAIL bypass_next got %h/%h exp a5a5a5a5", b1_rd1, b0_rd1); end
    endtask

    task automatic test_saturation;
        rd_addr1 = 3; rd_addr2 = 0;
        step(0, 0, 0, 1, 3);
        tests++; if (b1_rdy !== 1'b1 || b1_bz1 !== 1'b0) begin fails++; $display("FAIL sat_issue1 rdy %b busy %b exp 1 0", b1_rdy, b1_bz1); end
        step(0, 0, 0, 1, 3);
        tests++; if (b1_rdy !== 1'b1 || b1_bz1 !== 1'b1) begin fails++; $display("FAIL sat_issue2 rdy %b busy %b exp 1 1", b1_rdy, b1_bz1); end
        step(0, 0, 0, 1, 3);
        tests++; if (b1_rdy !== 1'b1) begin fails++; $display("FAIL sat_issue3 rdy got %b exp 1", b1_rdy); end
        step(0, 0, 0, 1, 3);
        tests++; if (b1_rdy !== 1'b0 || b0_rdy !== 1'b0) begin fails++; $display("FAIL sat_full rdy got %b/%b exp 0", b1_rdy, b0_rdy); end
        step(1, 3, 32'h33, 1, 3);
        tests++; if (b1_rdy !== 1'b1 || b0_rdy !== 1'b1) begin fails++; $display("FAIL sat_retire_issue rdy got %b/%b exp 1", b1_rdy, b0_rdy); end
        step(0, 0, 0, 1, 3);
        tests++; if (b1_rdy !== 1'b0) begin fails++; $display("FAIL sat_still3 rdy got %b exp 0", b1_rdy); end
        step(1, 3, 32'h34, 0, 0);
        tests++; if (b1_bz1 !== 1'b1 || b0_bz1 !== 1'b1) begin fails++; $display("FAIL drain3 busy got %b/%b exp 1", b1_bz1, b0_bz1); end
        step(1, 3, 32'h35, 0, 0);
        tests++; if (b1_bz1 !== 1'b1 || b0_bz1 !== 1'b1) begin fails++; $display("FAIL drain2 busy got %b/%b exp 1", b1_bz1, b0_bz1); end
        step(1, 3, 32'h36, 0, 0);
        tests++; if (b1_bz1 !== 1'b0 || b0_bz1 !== 1'b1) begin fails++; $display("FAIL drain1 busy got %b/%b exp 0/1", b1_bz1, b0_bz1); end
        step(0, 0, 0, 0, 0);
        tests++; if (b1_bz1 !== 1'b0 || b0_bz1 !== 1'b0 || b1_err !== 1'b0) begin fails++; $display("FAIL drained busy %b/%b err %b exp 0 0 0", b1_bz1, b0_bz1, b1_err); end
        tests++; if (b1_rd1 !== 32'h36) begin fails++; $display("FAIL drained_data got %h exp 36", b1_rd1); end
    endtask

    task automatic test_busy_bypass;
        rd_addr1 = 0; rd_addr2 = 9;
        step(0, 0, 0, 1, 9);
        tests++; if (b1_bz2 !== 1'b0 || b0_bz2 !== 1'b0) begin fails++; $display("FAIL issue_same_cycle busy got %b/%b exp 0", b1_bz2, b0_bz2); end
        step(1, 9, 32'h99, 0, 0);
        tests++; if (b1_bz2 !== 1'b0) begin fails++; $display("FAIL retire_bypass1 busy got %b exp 0", b1_bz2); end
        tests++; if (b0_bz2 !== 1'b1) begin fails++; $display("FAIL retire_bypass0 busy got %b exp 1", b0_bz2); end
        step(0, 0, 0, 0, 0);
        tests++; if (b1_bz2 !== 1'b0 || b0_bz2 !== 1'b0 || b0_err !== 1'b0) begin fails++; $display("FAIL retired busy %b/%b err %b exp 0 0 0", b1_bz2, b0_bz2, b0_err); end
    endtask

    task automatic test_underflow;
        rd_addr1 = 4; rd_addr2 = 0;
        step(1, 4, 32'h44444444, 0, 0);
        tests++; if (b1_err !== 1'b0) begin fails++; $display("FAIL uf_same_cycle err got %b exp 0", b1_err); end
        step(0, 0, 0, 0, 0);
        tests++; if (b1_err !== 1'b1 || b0_err !== 1'b1) begin fails++; $display("FAIL uf_err got %b/%b exp 1", b1_err, b0_err); end
        tests++; if (b1_rd1 !== 32'h44444444 || b1_bz1 !== 1'b0) begin fails++; $display("FAIL uf_write data %h busy %b exp 44444444 0", b1_rd1, b1_bz1); end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        tests++; if (b1_err !== 1'b1) begin fails++; $display("FAIL uf_sticky got %b exp 1", b1_err); end
        @(negedge clk); rst = 1;
        #1;
        tests++; if (b1_err !== 1'b0 || b0_err !== 1'b0) begin fails++; $display("FAIL uf_rst_clear got %b/%b exp 0", b1_err, b0_err); end
        @(negedge clk); rst = 0;
    endtask

    initial begin
        test_reset();
        test_r0_write();
        test_bypass();
        test_saturation();
        test_busy_bypass();
        test_underflow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
